mc_ctrl_hs: RTL and testbench

Parametrised successor to the multicycle MIPS control FSM. Adds a ready/valid memory handshake with wait states and a timeout, full internal ALU decode, illegal-instruction trapping and a retired-instruction counter. Sits between the instruction register and the multicycle datapath, and drives every datapath enable and mux select.

---
 rtl/mc_ctrl_hs_if.sv | 42 ++++
 rtl/mc_ctrl_hs.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_hs_if.sv
// mc_ctrl_hs_if: instruction-field, flag and control bundle between the
// multicycle control FSM (master) and the datapath/memory side (slave).
// Carries the instruction fields, the ALU zero flag, memory ready, every enable and select, and debug state.
interface mc_ctrl_hs_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             MemReady;
  logic             PCEn;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             RegDst;
  logic             MemToReg;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       PCSrc;
  logic             ExtOp;
  logic [2:0]       ALUCtl;
  logic             Link;
  logic             Illegal;
  logic [3:0]       State;
  logic [CNT_W-1:0] RetireCnt;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
           MemToReg, ALUSrcA, ALUSrcB, PCSrc, ExtOp, ALUCtl, Link,
           Illegal, State, RetireCnt
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
           MemToReg, ALUSrcA, ALUSrcB, PCSrc, ExtOp, ALUCtl, Link,
           Illegal, State, RetireCnt
  );
endinterface

// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle MIPS control FSM with memory ready handshake, wait timeout, illegal-instruction trap, retire counter.
// Latency: one state per cycle; FETCH/MEMRD/MEMWR stall until MemReady or timeout (MEM_TIMEOUT, 0 = never).
// Define MC_CTRL_JAL_EN to decode JAL (link to $31); otherwise JAL traps and Link stays 0.
module mc_ctrl_hs #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic          CLK,
  input logic          Reset,
  mc_ctrl_hs_if.master hs
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BEX    = 4'd8,
    IEX    = 4'd9,
    IWB    = 4'd10,
    JEX    = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`ifdef MC_CTRL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Wait counter only has to be wide enough to hold the limit itself.
  localparam int                WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  retire_q;

  logic       mem_state, timeout, op_jal;
  logic       funct_ok;
  logic [2:0] rtype_ctl, imm_ctl;
  logic       imm_ext;

  logic       pcen_c, irwrite_c, memread_c, memwrite_c, regwrite_c, link_c;
  logic       iord_c, regdst_c, memtoreg_c, alusrca_c, extop_c;
  logic [1:0] alusrcb_c, pcsrc_c;
  logic [2:0] aluctl_c;

  assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  // The limit only fires when MemReady is absent; a same-cycle ready still completes normally.
  assign timeout   = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT);

`ifdef MC_CTRL_JAL_EN
  assign op_jal = (hs.Op == OP_JAL);
`else
  assign op_jal = 1'b0;
`endif

  // R-type funct decode: ALU operation and whether the funct is supported
  always_comb begin
    funct_ok  = 1'b1;
    rtype_ctl = ALU_ADD;
    case (hs.Funct)
      FN_ADD:  rtype_ctl = ALU_ADD;
      FN_SUB:  rtype_ctl = ALU_SUB;
      FN_AND:  rtype_ctl = ALU_AND;
      FN_OR:   rtype_ctl = ALU_OR;
      FN_SLT:  rtype_ctl = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Immediate-class decode: ALU operation and sign/zero extension, shared by IEX and IWB
  always_comb begin
    imm_ctl = ALU_ADD;
    imm_ext = 1'b1;
    case (hs.Op)
      OP_SLTI: imm_ctl = ALU_SLT;
      OP_ANDI: begin imm_ctl = ALU_AND; imm_ext = 1'b0; end
      OP_ORI:  begin imm_ctl = ALU_OR;  imm_ext = 1'b0; end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic; memory states hold for MemReady and escape to TRAP on timeout
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  if (hs.MemReady) state_nxt = DECODE; else if (timeout) state_nxt = TRAP;
      DECODE: begin
        case (hs.Op)
          OP_LW, OP_SW:                      state_nxt = MEMADR;
          OP_RTYPE:                          state_nxt = funct_ok ? REX : TRAP;
          OP_BEQ, OP_BNE:                    state_nxt = BEX;
          OP_J:                              state_nxt = JEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_nxt = IEX;
          default:                           state_nxt = op_jal ? JEX : TRAP;
        endcase
      end
      MEMADR: state_nxt = (hs.Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (hs.MemReady) state_nxt = MEMWB; else if (timeout) state_nxt = TRAP;
      MEMWB:  state_nxt = FETCH;
      MEMWR:  if (hs.MemReady) state_nxt = FETCH; else if (timeout) state_nxt = TRAP;
      REX:    state_nxt = RWB;
      RWB:    state_nxt = FETCH;
      IEX:    state_nxt = IWB;
      IWB:    state_nxt = FETCH;
      BEX:    state_nxt = FETCH;
      JEX:    state_nxt = FETCH;
      TRAP:   state_nxt = TRAP;
      default: state_nxt = TRAP;
    endcase
  end

  // Control outputs per state; PCEn/IRWrite also follow MemReady (FETCH) and Zero (BEX)
  always_comb begin
    pcen_c     = 1'b0;
    irwrite_c  = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    link_c     = 1'b0;
    iord_c     = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    pcsrc_c    = 2'b00;
    extop_c    = 1'b0;
    aluctl_c   = ALU_ADD;
    case (state)
      FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = 2'b01;
        irwrite_c = hs.MemReady;
        pcen_c    = hs.MemReady;
      end
      DECODE: begin
        alusrcb_c = 2'b11;
        extop_c   = 1'b1;
      end
      MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        extop_c   = 1'b1;
      end
      MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
      end
      MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
      end
      MEMWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
      end
      REX: begin
        alusrca_c = 1'b1;
        aluctl_c  = rtype_ctl;
      end
      RWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
      end
      IEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        aluctl_c  = imm_ctl;
        extop_c   = imm_ext;
      end
      IWB: begin
        regwrite_c = 1'b1;
        aluctl_c   = imm_ctl;
        extop_c    = imm_ext;
      end
      BEX: begin
        alusrca_c = 1'b1;
        aluctl_c  = ALU_SUB;
        pcsrc_c   = 2'b01;
        pcen_c    = hs.Zero ^ hs.Op[0];
      end
      JEX: begin
        pcsrc_c = 2'b10;
        pcen_c  = 1'b1;
        if (op_jal) begin
          regwrite_c = 1'b1;
          link_c     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Wait counter: restarts on every state change, counts cycles spent waiting for MemReady
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                           wait_q <= '0;
    else if (state_nxt != state)         wait_q <= '0;
    else if (mem_state && !hs.MemReady)  wait_q <= wait_q + WAIT_W'(1);
  end

  // Sticky illegal flag, set as the FSM enters TRAP
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                  illegal_q <= 1'b0;
    else if (state_nxt == TRAP) illegal_q <= 1'b1;
  end

  // Retire counter: every completing state returns to FETCH, so count each such return
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                                   retire_q <= '0;
    else if (state != FETCH && state_nxt == FETCH) retire_q <= retire_q + CNT_W'(1);
  end

  assign hs.PCEn      = pcen_c     & ~Reset;
  assign hs.IRWrite   = irwrite_c  & ~Reset;
  assign hs.MemRead   = memread_c  & ~Reset;
  assign hs.MemWrite  = memwrite_c & ~Reset;
  assign hs.RegWrite  = regwrite_c & ~Reset;
  assign hs.Link      = link_c     & ~Reset;
  assign hs.IorD      = iord_c;
  assign hs.RegDst    = regdst_c;
  assign hs.MemToReg  = memtoreg_c;
  assign hs.ALUSrcA   = alusrca_c;
  assign hs.ALUSrcB   = alusrcb_c;
  assign hs.PCSrc     = pcsrc_c;
  assign hs.ExtOp     = extop_c;
  assign hs.ALUCtl    = aluctl_c;
  assign hs.Illegal   = illegal_q;
  assign hs.State     = state;
  assign hs.RetireCnt = retire_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// tb_mc_ctrl_hs: per-cycle vector table for mc_ctrl_hs with MEM_TIMEOUT = 4.
// Each vector carries the inputs for one cycle and the outputs expected in that cycle.
// Hand sequences cover trap, JAL and asynchronous reset corner cases.
module tb_mc_ctrl_hs;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_BAD  = 6'b000111;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7;
  localparam logic [3:0] S_BEX = 4'd8, S_IEX = 4'd9, S_IWB = 4'd10, S_JEX = 4'd11, S_TRAP = 4'd12;

  localparam int A_ADD = 2, A_SUB = 6, A_AND = 0, A_OR = 1, A_SLT = 7;
  localparam int D = -1;

  // strobes packed as {PCEn, IRWrite, MemRead, MemWrite, RegWrite, Link}
  localparam logic [5:0] NO  = 6'b000000;
  localparam logic [5:0] FST = 6'b111000;
  localparam logic [5:0] FWT = 6'b001000;
  localparam logic [5:0] MWT = 6'b000100;
  localparam logic [5:0] RW  = 6'b000010;
  localparam logic [5:0] PC  = 6'b100000;
  localparam logic [5:0] JL  = 6'b100011;

  logic CLK = 1'b0;
  logic Reset;

  mc_ctrl_hs_if #(.CNT_W(32)) hs();

  mc_ctrl_hs #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .hs    (hs)
  );

  always #5 CLK = ~CLK;

  // selects packed as {IorD, RegDst, MemToReg, ALUSrcA, ALUSrcB[1:0], PCSrc[1:0], ExtOp, ALUCtl[2:0]}
  typedef struct {
    logic [11:0] sel;
    logic [11:0] msk;
  } selm_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [5:0]  stb;
    logic [11:0] sel;
    logic [11:0] msk;
    logic        ill;
    int          ret;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vidx  = 0;

  selm_t F_S, FW_S, DEC_S, MA_S, MRD_S, MWB_S, MWR_S, BEX_S, JEX_S, TRP_S;

  function automatic selm_t s(int iord, int rd, int m2r, int sa, int sb, int ps, int ext, int alu);
    selm_t r;
    r.sel = '0;
    r.msk = '0;
    if (iord != D) begin r.sel[11]  = iord[0];  r.msk[11]  = 1'b1;   end
    if (rd   != D) begin r.sel[10]  = rd[0];    r.msk[10]  = 1'b1;   end
    if (m2r  != D) begin r.sel[9]   = m2r[0];   r.msk[9]   = 1'b1;   end
    if (sa   != D) begin r.sel[8]   = sa[0];    r.msk[8]   = 1'b1;   end
    if (sb   != D) begin r.sel[7:6] = sb[1:0];  r.msk[7:6] = 2'b11;  end
    if (ps   != D) begin r.sel[5:4] = ps[1:0];  r.msk[5:4] = 2'b11;  end
    if (ext  != D) begin r.sel[3]   = ext[0];   r.msk[3]   = 1'b1;   end
    if (alu  != D) begin r.sel[2:0] = alu[2:0]; r.msk[2:0] = 3'b111; end
    return r;
  endfunction

  function automatic vec_t mk(logic [5:0] op, logic [5:0] fn, logic z, logic mr, logic [3:0] st,
                              logic [5:0] stb, selm_t sm, logic ill, int ret);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.st = st; v.stb = stb;
    v.sel = sm.sel; v.msk = sm.msk; v.ill = ill; v.ret = ret;
    return v;
  endfunction

  function automatic void add(logic [5:0] op, logic [5:0] fn, logic z, logic mr, logic [3:0] st,
                              logic [5:0] stb, selm_t sm, logic ill, int ret);
    tbl.push_back(mk(op, fn, z, mr, st, stb, sm, ill, ret));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one cycle of inputs and queue what the DUT must show during that cycle
  task automatic cyc(vec_t v);
    hs.Op       = v.op;
    hs.Funct    = v.fn;
    hs.Zero     = v.z;
    hs.MemReady = v.mr;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk("reset state",   32'(hs.State), 32'(S_FETCH));
    chk("reset strobes", 32'({hs.PCEn, hs.IRWrite, hs.MemRead, hs.MemWrite, hs.RegWrite, hs.Link}), 32'(NO));
    chk("reset illegal", 32'(hs.Illegal), 32'd0);
    chk("reset retire",  hs.RetireCnt, 32'd0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
  endtask

  // scoreboard: compare the oldest queued expectation on the falling edge
  always @(negedge CLK) begin
    vec_t        e;
    logic [11:0] asel;
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      asel = {hs.IorD, hs.RegDst, hs.MemToReg, hs.ALUSrcA, hs.ALUSrcB, hs.PCSrc, hs.ExtOp, hs.ALUCtl};
      chk($sformatf("v%0d state", vidx), 32'(hs.State), 32'(e.st));
      chk($sformatf("v%0d strobes", vidx),
          32'({hs.PCEn, hs.IRWrite, hs.MemRead, hs.MemWrite, hs.RegWrite, hs.Link}), 32'(e.stb));
      chk($sformatf("v%0d selects", vidx), 32'(asel & e.msk), 32'(e.sel));
      chk($sformatf("v%0d illegal", vidx), 32'(hs.Illegal), 32'(e.ill));
      chk($sformatf("v%0d retire", vidx), hs.RetireCnt, e.ret);
      vidx++;
    end
  end

  initial begin
    hs.Op = '0; hs.Funct = '0; hs.Zero = 1'b0; hs.MemReady = 1'b0;
    Reset = 1'b0;

    F_S   = s(0, D, D, 0, 1, 0, D, A_ADD);
    FW_S  = s(0, D, D, D, D, D, D, D);
    DEC_S = s(D, D, D, 0, 3, D, 1, A_ADD);
    MA_S  = s(D, D, D, 1, 2, D, 1, A_ADD);
    MRD_S = s(1, D, D, D, D, D, D, D);
    MWB_S = s(D, 0, 1, D, D, D, D, D);
    MWR_S = s(1, D, D, D, D, D, D, D);
    BEX_S = s(D, D, D, 1, 0, 1, D, A_SUB);
    JEX_S = s(D, D, D, D, D, 2, D, D);
    TRP_S = s(D, D, D, D, D, D, D, D);

    // LW: ready at once in FETCH, three wait cycles in MEMRD
    add(OP_LW, 0, 0, 1, S_FETCH,  FST, F_S,   0, 0);
    add(OP_LW, 0, 0, 0, S_DECODE, NO,  DEC_S, 0, 0);
    add(OP_LW, 0, 0, 0, S_MEMADR, NO,  MA_S,  0, 0);
    for (int i = 0; i < 3; i++) add(OP_LW, 0, 0, 0, S_MEMRD, FWT, MRD_S, 0, 0);
    add(OP_LW, 0, 0, 1, S_MEMRD,  FWT, MRD_S, 0, 0);
    add(OP_LW, 0, 0, 0, S_MEMWB,  RW,  MWB_S, 0, 0);
    // BNE not-zero takes, BEQ not-zero falls through, BEQ zero takes
    add(OP_BNE, 0, 0, 1, S_FETCH,  FST, F_S,   0, 1);
    add(OP_BNE, 0, 0, 0, S_DECODE, NO,  DEC_S, 0, 1);
    add(OP_BNE, 0, 0, 0, S_BEX,    PC,  BEX_S, 0, 1);
    add(OP_BEQ, 0, 0, 1, S_FETCH,  FST, F_S,   0, 2);
    add(OP_BEQ, 0, 0, 0, S_DECODE, NO,  DEC_S, 0, 2);
    add(OP_BEQ, 0, 0, 0, S_BEX,    NO,  BEX_S, 0, 2);
    add(OP_BEQ, 0, 1, 1, S_FETCH,  FST, F_S,   0, 3);
    add(OP_BEQ, 0, 1, 0, S_DECODE, NO,  DEC_S, 0, 3);
    add(OP_BEQ, 0, 1, 0, S_BEX,    PC,  BEX_S, 0, 3);
    // ANDI then SLTI
    add(OP_ANDI, 0, 0, 1, S_FETCH,  FST, F_S,   0, 4);
    add(OP_ANDI, 0, 0, 0, S_DECODE, NO,  DEC_S, 0, 4);
    add(OP_ANDI, 0, 0, 0, S_IEX,    NO,  s(D, D, D, 1, 2, D, 0, A_AND), 0, 4);
    add(OP_ANDI, 0, 0, 0, S_IWB,    RW,  s(D, 0, 0, D, D, D, 0, A_AND), 0, 4);
    add(OP_SLTI, 0, 0, 1, S_FETCH,  FST, F_S,   0, 5);
    add(OP_SLTI, 0, 0, 0, S_DECODE, NO,  DEC_S, 0, 5);
    add(OP_SLTI, 0, 0, 0, S_IEX,    NO,  s(D, D, D, 1, 2, D, 1, A_SLT), 0, 5);
    add(OP_SLTI, 0, 0, 0, S_IWB,    RW,  s(D, 0, 0, D, D, D, 1, A_SLT), 0, 5);
    // R-type SUB
    add(OP_R, FN_SUB, 0, 1, S_FETCH,  FST, F_S,   0, 6);
    add(OP_R, FN_SUB, 0, 0, S_DECODE, NO,  DEC_S, 0, 6);
    add(OP_R, FN_SUB, 0, 0, S_REX,    NO,  s(D, D, D, 1, 0, D, D, A_SUB), 0, 6);
    add(OP_R, FN_SUB, 0, 0, S_RWB,    RW,  s(D, 1, 0, D, D, D, D, D),     0, 6);
    // SW: two FETCH wait cycles, stray MemReady in DECODE/MEMADR, MEMWR ready at once
    add(OP_SW, 0, 0, 0, S_FETCH,  FWT, FW_S,  0, 7);
    add(OP_SW, 0, 0, 0, S_FETCH,  FWT, FW_S,  0, 7);
    add(OP_SW, 0, 0, 1, S_FETCH,  FST, F_S,   0, 7);
    add(OP_SW, 0, 0, 1, S_DECODE, NO,  DEC_S, 0, 7);
    add(OP_SW, 0, 0, 1, S_MEMADR, NO,  MA_S,  0, 7);
    add(OP_SW, 0, 0, 1, S_MEMWR,  MWT, MWR_S, 0, 7);
    // J
    add(OP_J, 0, 0, 1, S_FETCH,  FST, F_S,   0, 8);
    add(OP_J, 0, 0, 0, S_DECODE, NO,  DEC_S, 0, 8);
    add(OP_J, 0, 0, 0, S_JEX,    PC,  JEX_S, 0, 8);
    // ORI: MemReady arrives in the cycle the wait count sits at the limit and still wins
    for (int i = 0; i < 4; i++) add(OP_ORI, 0, 0, 0, S_FETCH, FWT, FW_S, 0, 9);
    add(OP_ORI, 0, 0, 1, S_FETCH,  FST, F_S,   0, 9);
    add(OP_ORI, 0, 0, 0, S_DECODE, NO,  DEC_S, 0, 9);
    add(OP_ORI, 0, 0, 0, S_IEX,    NO,  s(D, D, D, 1, 2, D, 0, A_OR), 0, 9);
    add(OP_ORI, 0, 0, 0, S_IWB,    RW,  s(D, 0, 0, D, D, D, 0, A_OR), 0, 9);
    // fetch timeout: five cycles without MemReady, then TRAP ignores MemReady
    for (int i = 0; i < 5; i++) add(OP_LW, 0, 0, 0, S_FETCH, FWT, FW_S, 0, 10);
    add(OP_LW, 0,      0, 1, S_TRAP, NO, TRP_S, 1, 10);
    add(OP_LW, 0,      0, 1, S_TRAP, NO, TRP_S, 1, 10);
    add(OP_R,  FN_SUB, 1, 1, S_TRAP, NO, TRP_S, 1, 10);

    #2;
    do_reset();
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

    // unsupported R-type funct traps right after DECODE
    do_reset();
    cyc(mk(OP_R, FN_BAD, 0, 1, S_FETCH,  FST, F_S,   0, 0));
    cyc(mk(OP_R, FN_BAD, 0, 0, S_DECODE, NO,  DEC_S, 0, 0));
    cyc(mk(OP_R, FN_BAD, 0, 1, S_TRAP,   NO,  TRP_S, 1, 0));

    // JAL links when enabled, traps otherwise
    do_reset();
    cyc(mk(OP_JAL, 0, 0, 1, S_FETCH,  FST, F_S,   0, 0));
    cyc(mk(OP_JAL, 0, 0, 0, S_DECODE, NO,  DEC_S, 0, 0));
`ifdef MC_CTRL_JAL_EN
    cyc(mk(OP_JAL, 0, 0, 0, S_JEX,    JL,  JEX_S, 0, 0));
    cyc(mk(OP_JAL, 0, 0, 0, S_FETCH,  FWT, FW_S,  0, 1));
`else
    cyc(mk(OP_JAL, 0, 0, 0, S_TRAP,   NO,  TRP_S, 1, 0));
`endif

    // asynchronous reset in the middle of a stalled MEMWR
    do_reset();
    cyc(mk(OP_J,  0, 0, 1, S_FETCH,  FST, F_S,   0, 0));
    cyc(mk(OP_J,  0, 0, 0, S_DECODE, NO,  DEC_S, 0, 0));
    cyc(mk(OP_J,  0, 0, 0, S_JEX,    PC,  JEX_S, 0, 0));
    cyc(mk(OP_SW, 0, 0, 1, S_FETCH,  FST, F_S,   0, 1));
    cyc(mk(OP_SW, 0, 0, 0, S_DECODE, NO,  DEC_S, 0, 1));
    cyc(mk(OP_SW, 0, 0, 0, S_MEMADR, NO,  MA_S,  0, 1));
    cyc(mk(OP_SW, 0, 0, 0, S_MEMWR,  MWT, MWR_S, 0, 1));
    #2;
    chk("memwr before reset", 32'(hs.MemWrite), 32'd1);
    Reset = 1'b1;
    #1;
    chk("async reset state",    32'(hs.State), 32'(S_FETCH));
    chk("async reset memwrite", 32'(hs.MemWrite), 32'd0);
    chk("async reset memread",  32'(hs.MemRead), 32'd0);
    chk("async reset retire",   hs.RetireCnt, 32'd0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    @(negedge CLK);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
